// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot loader that streams a framed, checksummed program image into
//            instruction memory and releases the core once it is verified.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [15:0]           word_count_q, word_count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic                  rx_ready_w;
    logic                  accept_w;
    logic [15:0]           hdr_len_w;
    logic [15:0]           next_count_w;

    assign rx_ready_w   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept_w     = rx_valid && rx_ready_w;
    assign hdr_len_w    = {rx_data, len_q[7:0]};
    assign next_count_w = word_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        word_count_d = word_count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LEN_LO;
                    word_count_d = 16'd0;
                    csum_d       = 8'd0;
                    byte_idx_d   = 2'd0;
                end
            end
            S_LEN_LO: begin
                if (accept_w) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept_w) begin
                    len_d[15:8] = rx_data;
                    if ({1'b0, hdr_len_w} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (hdr_len_w == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_w) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            // Top byte goes straight into the write register.
                            mem_we_d     = 1'b1;
                            mem_wdata_d  = {rx_data, word_q};
                            mem_addr_d   = word_count_q[ADDR_WIDTH-1:0];
                            word_count_d = next_count_w;
                            if (next_count_w == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (accept_w) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            len_q        <= 16'd0;
            word_q       <= 24'd0;
            byte_idx_q   <= 2'd0;
            csum_q       <= 8'd0;
            word_count_q <= 16'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            word_count_q <= word_count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign rx_ready   = rx_ready_w;
    assign busy       = rx_ready_w;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign core_hold  = (state_q != S_DONE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;

endmodule

`default_nettype wire
